// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and width helpers for the set-associative data cache.
package dcache_pkg;

    localparam int DC_LINE_W = 256;
    localparam int OFF_W     = 5;
    localparam int ADDR_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_REFILL    = 2'd3
    } state_e;

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int sets);
        return ADDR_W - OFF_W - $clog2(sets);
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 32'sd1) ? $clog2(ways) : 32'sd1;
    endfunction

    // A direct-mapped cache still carries one dummy PLRU bit so arrays stay non-empty.
    function automatic int plru_width(input int ways);
        return (ways > 32'sd1) ? (ways - 32'sd1) : 32'sd1;
    endfunction

endpackage

// File: rtl/dcache_assoc_plru_tree.sv
// Tree pseudo-LRU: node n has children 2n+1 / 2n+2; a bit value of 1 points the victim to the right half.
module plru_tree
    import dcache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int PLRU_W = plru_width(WAYS),
    parameter int WAY_W  = way_width(WAYS)
) (
    input  logic [PLRU_W-1:0] plru,
    input  logic [WAY_W-1:0]  hit_way,
    output logic [PLRU_W-1:0] plru_next,
    output logic [WAY_W-1:0]  victim
);

    generate
        if (WAYS == 1) begin : g_single
            logic unused_s;
            assign unused_s  = ^hit_way;
            assign plru_next = plru;
            assign victim    = '0;
        end else begin : g_tree
            localparam int LVL = $clog2(WAYS);

            // Walk the hit way's path and flip each node to point away from it.
            always_comb begin
                int node;
                node      = 32'sd0;
                plru_next = plru;
                for (int l = 0; l < LVL; l++) begin
                    plru_next[node] = ~hit_way[LVL-1-l];
                    node = 32'sd2 * node + 32'sd1 + int'(hit_way[LVL-1-l]);
                end
            end

            // Follow the node bits from the root down to the least recently used leaf.
            always_comb begin
                int node;
                node   = 32'sd0;
                victim = '0;
                for (int l = 0; l < LVL; l++) begin
                    victim[LVL-1-l] = plru[node];
                    node = 32'sd2 * node + 32'sd1 + int'(plru[node]);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back / write-allocate data cache between the MEM stage and Data_Memory.
// Lookup and hit data are combinational; the miss engine and memory-side outputs are registered.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int LINE_W = DC_LINE_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int IDX_W  = idx_width(SETS);
    localparam int TAG_W  = tag_width(SETS);
    localparam int WAY_W  = way_width(WAYS);
    localparam int PLRU_W = plru_width(WAYS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
    logic [LINE_W-1:0] data_r  [SETS][WAYS];
    logic [WAYS-1:0]   valid_r [SETS];
    logic [WAYS-1:0]   dirty_r [SETS];
    logic [PLRU_W-1:0] plru_r  [SETS];

    state_e            state_r;
    logic [WAY_W-1:0]  vway_r;
    logic [IDX_W-1:0]  idx_r;
    logic [TAG_W-1:0]  rtag_r;
    logic              mem_enable_r;
    logic              mem_write_r;
    logic [31:0]       mem_addr_r;
    logic [LINE_W-1:0] mem_data_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;

    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [2:0]        word_s;
    logic              req_s;
    logic [WAYS-1:0]   match_s;
    logic              hit_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic              inv_found_s;
    logic [WAY_W-1:0]  inv_way_s;
    logic [WAY_W-1:0]  plru_victim_s;
    logic [WAY_W-1:0]  victim_s;
    logic              victim_dirty_s;
    logic [PLRU_W-1:0] plru_next_s;
    logic [LINE_W-1:0] hit_line_s;
    logic              hit_ok_s;
    logic              unused_s;

    assign idx_s    = p1_addr_i[OFF_W +: IDX_W];
    assign tag_s    = p1_addr_i[31 -: TAG_W];
    assign word_s   = p1_addr_i[4:2];
    assign req_s    = p1_MemRead_i | p1_MemWrite_i;
    assign unused_s = ^p1_addr_i[1:0];

    // Tag match across the indexed set; lowest matching and lowest invalid way win.
    always_comb begin
        hit_way_s = '0;
        inv_way_s = '0;
        match_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            match_s[w] = valid_r[idx_s][w] & (tag_r[idx_s][w] == tag_s);
            hit_way_s  = match_s[w]         ? WAY_W'(w) : hit_way_s;
            inv_way_s  = !valid_r[idx_s][w] ? WAY_W'(w) : inv_way_s;
        end
    end

    assign hit_s          = |match_s;
    assign inv_found_s    = ~&valid_r[idx_s];
    assign victim_s       = inv_found_s ? inv_way_s : plru_victim_s;
    assign victim_dirty_s = valid_r[idx_s][victim_s] & dirty_r[idx_s][victim_s];
    assign hit_line_s     = data_r[idx_s][hit_way_s];
    assign hit_ok_s       = req_s & hit_s & (state_r == ST_IDLE);

    assign p1_data_o  = hit_s ? hit_line_s[{word_s, 5'd0} +: 32] : 32'd0;
    assign p1_stall_o = req_s & (~hit_s | (state_r != ST_IDLE));

    plru_tree #(
        .WAYS   (WAYS),
        .PLRU_W (PLRU_W),
        .WAY_W  (WAY_W)
    ) u_plru (
        .plru      (plru_r[idx_s]),
        .hit_way   (hit_way_s),
        .plru_next (plru_next_s),
        .victim    (plru_victim_s)
    );

    // Line storage: hit-side store merge and PLRU touch, refill capture and line install.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= '{default: '0};
            dirty_r <= '{default: '0};
            plru_r  <= '{default: '0};
        end else if (hit_ok_s) begin
            plru_r[idx_s] <= plru_next_s;
            if (p1_MemWrite_i) begin
                data_r[idx_s][hit_way_s][{word_s, 5'd0} +: 32] <= p1_data_i;
                dirty_r[idx_s][hit_way_s] <= 1'b1;
            end
        end else if (state_r == ST_ALLOCATE && mem_enable_r && mem_ack_i) begin
            data_r[idx_r][vway_r] <= mem_data_i;
        end else if (state_r == ST_REFILL) begin
            tag_r[idx_r][vway_r]   <= rtag_r;
            valid_r[idx_r][vway_r] <= 1'b1;
            dirty_r[idx_r][vway_r] <= 1'b0;
        end
    end

    // Miss engine with registered memory-side outputs and performance counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            vway_r       <= '0;
            idx_r        <= '0;
            rtag_r       <= '0;
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_data_r   <= '0;
            hit_cnt_r    <= '0;
            miss_cnt_r   <= '0;
        end else begin
            if (hit_ok_s) begin
                hit_cnt_r <= hit_cnt_r + CNT_ONE;
            end
            case (state_r)
                ST_IDLE: begin
                    if (req_s && !hit_s) begin
                        miss_cnt_r   <= miss_cnt_r + CNT_ONE;
                        vway_r       <= victim_s;
                        idx_r        <= idx_s;
                        rtag_r       <= tag_s;
                        mem_enable_r <= 1'b1;
                        if (victim_dirty_s) begin
                            state_r     <= ST_WRITEBACK;
                            mem_write_r <= 1'b1;
                            mem_addr_r  <= {tag_r[idx_s][victim_s], idx_s, 5'd0};
                            mem_data_r  <= data_r[idx_s][victim_s];
                        end else begin
                            state_r     <= ST_ALLOCATE;
                            mem_write_r <= 1'b0;
                            mem_addr_r  <= {tag_s, idx_s, 5'd0};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    // Enable drops for one cycle after the write-back ack before the refill is issued.
                    if (mem_ack_i) begin
                        state_r      <= ST_ALLOCATE;
                        mem_enable_r <= 1'b0;
                        mem_write_r  <= 1'b0;
                        mem_addr_r   <= {rtag_r, idx_r, 5'd0};
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_enable_r && mem_ack_i) begin
                        state_r      <= ST_REFILL;
                        mem_enable_r <= 1'b0;
                    end else if (!mem_enable_r) begin
                        mem_enable_r <= 1'b1;
                    end
                end
                ST_REFILL: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    mem_enable_r <= 1'b0;
                    mem_write_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_enable_o = mem_enable_r;
    assign mem_write_o  = mem_write_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;
    assign hit_cnt_o    = hit_cnt_r;
    assign miss_cnt_o   = miss_cnt_r;

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (WAYS=2, SETS=16) against a latency-L line memory model.
module tb_dcache_assoc;

    localparam int L = 10;

    logic         clk;
    logic         rst;
    logic [31:0]  p1_addr;
    logic [31:0]  p1_wdata;
    logic         p1_rd;
    logic         p1_wr;
    logic [31:0]  p1_rdata;
    logic         p1_stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_en;
    logic         mem_we;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic         ack_m;
    logic         ack_f;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] mem_m [64];
    bit           mute = 1'b0;
    int           wb_cnt = 0;
    int           seq = 0;
    int           wb_seq = 0;
    int           alloc_seq = 0;
    logic [31:0]  wb_addr = 32'd0;
    logic [255:0] wb_data = '0;
    logic [31:0]  alloc_addr = 32'd0;
    int           stab_err = 0;

    assign mem_ack = ack_m | ack_f;

    dcache_assoc #(.WAYS(2), .SETS(16), .LINE_W(256), .CNT_W(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .p1_addr_i     (p1_addr),
        .p1_data_i     (p1_wdata),
        .p1_MemRead_i  (p1_rd),
        .p1_MemWrite_i (p1_wr),
        .p1_data_o     (p1_rdata),
        .p1_stall_o    (p1_stall),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_enable_o  (mem_en),
        .mem_write_o   (mem_we),
        .mem_data_i    (mem_rdata),
        .mem_ack_i     (mem_ack),
        .hit_cnt_o     (hit_cnt),
        .miss_cnt_o    (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] line_pat(input int n);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) begin
            v[k*32 +: 32] = 32'hA000_0000 | (32'(n) << 8) | 32'(k);
        end
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: acks in the L-th consecutive enabled cycle, logs requests, checks stability.
    initial begin
        int cnt;
        logic [31:0] a0;
        logic        w0;
        logic [255:0] d0;
        cnt = 0; ack_m = 1'b0; mem_rdata = '0;
        a0 = 32'd0; w0 = 1'b0; d0 = '0;
        for (int i = 0; i < 64; i++) mem_m[i] = line_pat(i);
        forever begin
            @(negedge clk);
            if (mem_en && !mute) begin
                cnt++;
                if (cnt == 1) begin
                    seq++;
                    a0 = mem_addr; w0 = mem_we; d0 = mem_wdata;
                    if (mem_we) begin
                        wb_cnt++; wb_seq = seq; wb_addr = mem_addr; wb_data = mem_wdata;
                    end else begin
                        alloc_seq = seq; alloc_addr = mem_addr;
                    end
                end else if (mem_addr !== a0 || mem_we !== w0 || (w0 && mem_wdata !== d0)) begin
                    stab_err++;
                end
                if (cnt == L) begin
                    ack_m = 1'b1;
                    if (mem_we) mem_m[mem_addr[10:5]] = mem_wdata;
                    else mem_rdata = mem_m[mem_addr[10:5]];
                end else begin
                    ack_m = 1'b0;
                end
            end else begin
                cnt = 0;
                ack_m = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; p1_rd = 1'b0; p1_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output int stalls, output logic [31:0] rdata);
        int n;
        bit done;
        @(negedge clk);
        p1_addr = addr; p1_wdata = wdata; p1_rd = ~wr; p1_wr = wr;
        n = 0; done = 1'b0; rdata = 32'd0;
        while (!done && n < 200) begin
            #1;
            if (!p1_stall) begin
                done = 1'b1;
                rdata = p1_rdata;
            end else begin
                n++;
                @(negedge clk);
            end
        end
        check_eq("access_done", 256'(done), 256'(1));
        @(posedge clk);
        #1;
        p1_rd = 1'b0; p1_wr = 1'b0;
        stalls = n;
    endtask

    initial begin
        int st;
        int wb0;
        logic [31:0] rd;
        logic [255:0] exp_line;
        rst = 1'b1; p1_addr = 32'd0; p1_wdata = 32'd0; p1_rd = 1'b0; p1_wr = 1'b0; ack_f = 1'b0;
        do_reset();
        #1;
        check_eq("rst_hit_cnt", 256'(hit_cnt), 256'(0));
        check_eq("rst_miss_cnt", 256'(miss_cnt), 256'(0));
        check_eq("rst_mem_en", 256'(mem_en), 256'(0));
        check_eq("rst_mem_we", 256'(mem_we), 256'(0));
        check_eq("rst_mem_addr", 256'(mem_addr), 256'(0));
        check_eq("rst_mem_data", mem_wdata, 256'(0));
        check_eq("rst_stall", 256'(p1_stall), 256'(0));
        check_eq("rst_rdata", 256'(p1_rdata), 256'(0));

        // Cold read miss on 0x40.
        access(32'h40, 1'b0, 32'd0, st, rd);
        check_eq("cold_stall", 256'(st), 256'(L + 2));
        check_eq("cold_data", 256'(rd), 256'(32'hA000_0200));
        check_eq("cold_alloc_addr", 256'(alloc_addr), 256'(32'h40));
        check_eq("cold_no_wb", 256'(wb_cnt), 256'(0));
        check_eq("cold_miss_cnt", 256'(miss_cnt), 256'(1));
        check_eq("cold_hit_cnt", 256'(hit_cnt), 256'(1));

        // Store hit then load hit.
        access(32'h44, 1'b1, 32'hDEAD_BEEF, st, rd);
        check_eq("st_hit_stall", 256'(st), 256'(0));
        access(32'h44, 1'b0, 32'd0, st, rd);
        check_eq("ld_hit_stall", 256'(st), 256'(0));
        check_eq("ld_hit_data", 256'(rd), 256'(32'hDEAD_BEEF));
        check_eq("hit_cnt_3", 256'(hit_cnt), 256'(3));

        // Conflict A: dirty 0x000 stays, clean 0x200 is the victim for 0x400.
        do_reset();
        wb0 = wb_cnt;
        access(32'h000, 1'b0, 32'd0, st, rd);
        check_eq("a_ld000_data", 256'(rd), 256'(32'hA000_0000));
        access(32'h200, 1'b0, 32'd0, st, rd);
        check_eq("a_ld200_data", 256'(rd), 256'(32'hA000_1000));
        access(32'h000, 1'b1, 32'h1234_5678, st, rd);
        access(32'h400, 1'b0, 32'd0, st, rd);
        check_eq("a_ld400_stall", 256'(st), 256'(L + 2));
        check_eq("a_ld400_data", 256'(rd), 256'(32'hA000_2000));
        check_eq("a_no_wb", 256'(wb_cnt), 256'(wb0));
        access(32'h000, 1'b0, 32'd0, st, rd);
        check_eq("a_ld000_kept", 256'(rd), 256'(32'h1234_5678));
        check_eq("a_ld000_stall", 256'(st), 256'(0));
        check_eq("a_miss_cnt", 256'(miss_cnt), 256'(3));
        check_eq("a_hit_cnt", 256'(hit_cnt), 256'(5));

        // Conflict B: dirty 0x200 becomes the PLRU victim and is written back first.
        do_reset();
        wb0 = wb_cnt;
        access(32'h000, 1'b0, 32'd0, st, rd);
        access(32'h200, 1'b0, 32'd0, st, rd);
        access(32'h204, 1'b1, 32'hCAFE_F00D, st, rd);
        access(32'h000, 1'b0, 32'd0, st, rd);
        access(32'h400, 1'b0, 32'd0, st, rd);
        check_eq("b_dirty_stall", 256'(st), 256'(2 * L + 3));
        check_eq("b_wb_count", 256'(wb_cnt), 256'(wb0 + 1));
        check_eq("b_wb_addr", 256'(wb_addr), 256'(32'h200));
        exp_line = line_pat(16);
        exp_line[63:32] = 32'hCAFE_F00D;
        check_eq("b_wb_data", wb_data, exp_line);
        check_eq("b_alloc_addr", 256'(alloc_addr), 256'(32'h400));
        check_eq("b_wb_before_alloc", 256'(wb_seq + 1), 256'(alloc_seq));
        check_eq("b_ld400_data", 256'(rd), 256'(32'hA000_2000));
        access(32'h204, 1'b0, 32'd0, st, rd);
        check_eq("b_reload_stall", 256'(st), 256'(L + 2));
        check_eq("b_reload_data", 256'(rd), 256'(32'hCAFE_F00D));
        check_eq("b_miss_cnt", 256'(miss_cnt), 256'(4));
        check_eq("b_hit_cnt", 256'(hit_cnt), 256'(6));
        check_eq("mem_if_stable", 256'(stab_err), 256'(0));

        // Reset while a refill is outstanding.
        do_reset();
        mute = 1'b1;
        @(negedge clk);
        p1_addr = 32'h40; p1_rd = 1'b1;
        for (int i = 0; i < 20 && !mem_en; i++) @(negedge clk);
        #1;
        check_eq("r_alloc_en", 256'(mem_en), 256'(1));
        check_eq("r_alloc_we", 256'(mem_we), 256'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1; p1_rd = 1'b0;
        @(posedge clk);
        #1;
        check_eq("r_en_drop", 256'(mem_en), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        ack_f = 1'b1;
        @(negedge clk);
        ack_f = 1'b0;
        @(negedge clk);
        #1;
        check_eq("r_late_ack_en", 256'(mem_en), 256'(0));
        check_eq("r_miss_cnt0", 256'(miss_cnt), 256'(0));
        mute = 1'b0;
        access(32'h40, 1'b0, 32'd0, st, rd);
        check_eq("r_remiss_stall", 256'(st), 256'(L + 2));
        check_eq("r_remiss_data", 256'(rd), 256'(32'hA000_0200));
        check_eq("r_miss_cnt1", 256'(miss_cnt), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised set-associative write-back, write-allocate data cache. It replaces the direct-mapped `dcache_top` between the CPU MEM stage and `Data_Memory`, and keeps the same CPU-side and memory-side port contract. Associativity and set count are configurable, replacement is tree pseudo-LRU, and hit/miss counters are exposed for performance runs. Its `p1_stall_o` drives the pipeline-wide stall, which freezes PC, all pipeline buffers and the MEM-stage request.

## Interface
- `WAYS`, 2: associativity; legal values are 1, 2, 4, 8.
- `SETS`, 16: number of sets; power of two, minimum 2.
- `LINE_W`, 256: line width in bits; fixed by `Data_Memory`.
- `CNT_W`, 32: width of the hit and miss counters.
- `clk_i`  in  1: single clock. All state updates on the rising edge.
- `rst_i`  in  1: reset, synchronous and active-high.
- `p1_addr_i`  in  32: byte address. Fields: [4:2] word, [4+log2(SETS):5] index, upper bits tag.
- `p1_data_i`  in  32: store data.
- `p1_MemRead_i`  in  1: load request.
- `p1_MemWrite_i`  in  1: store request. Takes priority when both requests are set.
- `p1_data_o`  out  32: load data. Combinational on a hit.
- `p1_stall_o`  out  1: high while the current request is not yet satisfied.
- `mem_addr_o`  out  32: line address; low 5 bits are zero.
- `mem_data_o`  out  `LINE_W`: write-back data.
- `mem_enable_o`  out  1: memory request.
- `mem_write_o`  out  1: 1 = write-back, 0 = refill.
- `mem_data_i`  in  `LINE_W`: refill data.
- `mem_ack_i`  in  1: single-cycle completion pulse.
- `hit_cnt_o`  out  `CNT_W`: number of hit accesses.
- `miss_cnt_o`  out  `CNT_W`: number of miss events.

## Operation
- A request is active when `p1_MemRead_i | p1_MemWrite_i`. The tag is compared across all ways of the indexed set. Hit = valid and tag equal.
- Read hit: `p1_data_o` = selected word, same cycle; `p1_stall_o` = 0. When there is no hit, `p1_data_o` = 0.
- Write hit: the word is merged into the line at the next edge and the line's dirty bit is set. `p1_stall_o` = 0.
- Every hit updates the set's PLRU bits (`WAYS-1` bits per set) to point away from the hit way. When `WAYS` = 1 there are no PLRU bits.
- Victim selection: the first invalid way (lowest index); otherwise the way indicated by PLRU.
- FSM states and transitions:
  - IDLE: on a miss, go to WRITEBACK if the victim is valid and dirty, otherwise go to ALLOCATE. `miss_cnt_o` increments once, on this transition.
  - WRITEBACK: `mem_enable_o` = 1, `mem_write_o` = 1, `mem_addr_o` = {victim tag, index, 5'b0}, `mem_data_o` = victim line. On `mem_ack_i`, go to ALLOCATE.
  - ALLOCATE: `mem_enable_o` = 1, `mem_write_o` = 0, `mem_addr_o` = {request tag, index, 5'b0}. On `mem_ack_i`, capture `mem_data_i` into the victim way and go to REFILL.
  - REFILL: set valid = 1, dirty = 0, tag = request tag. `mem_enable_o` = 0. Go to IDLE.
- Back in IDLE, the still-held request now hits and completes through the normal hit path. That completion counts as a hit.
- `p1_stall_o` = request active AND (not hit OR FSM not IDLE).
- The victim way and its address are latched on leaving IDLE. They do not change while the miss is in progress, even if inputs change.
- `hit_cnt_o` increments on every cycle with an active request, a hit, and FSM in IDLE. Both counters wrap modulo 2^`CNT_W`.

## Timing
- Reset: all valid, dirty and PLRU bits cleared; FSM = IDLE; `mem_enable_o` = 0, `mem_write_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0; both counters = 0.
  - `p1_stall_o` and `p1_data_o` are combinational and follow from the cleared state.
- Reset during a miss: the transaction is abandoned and `mem_enable_o` is low the cycle after the reset edge. A late `mem_ack_i` seen in IDLE is ignored.
- Memory handshake:
  - `mem_enable_o`, `mem_addr_o`, `mem_write_o` and `mem_data_o` stay stable from the first cycle of WRITEBACK or ALLOCATE until the cycle in which `mem_ack_i` is sampled.
  - `mem_enable_o` drops in the cycle after the ack.
  - An ack outside WRITEBACK or ALLOCATE has no effect.
- Miss latency is measured from the miss cycle to the cycle in which stall deasserts, with memory ack latency L:
  - clean miss: L + 2 cycles;
  - dirty miss: 2L + 3 cycles.
- Hit latency is 0 cycles: no stall.

## Structure
- Package `dcache_pkg`:
  - FSM state enum (IDLE, WRITEBACK, ALLOCATE, REFILL);
  - `LINE_W` and offset width;
  - functions that compute index and tag widths from `SETS`.
- Sub-module `plru_tree`: combinational. Takes the PLRU bits and a hit way; produces the updated PLRU bits and the victim way. Parametrised by `WAYS`.
- Tag, valid, dirty and data arrays are register arrays inside `dcache_assoc`.

## Test plan
- After reset, read 0x0000_0040 with memory L = 10:
  - `mem_enable_o` high with `mem_addr_o` = 0x40, `mem_write_o` = 0;
  - stall held for 12 cycles, then data = word 0 of the refilled line;
  - `miss_cnt_o` = 1, `hit_cnt_o` = 1.
- Store 0xDEADBEEF to 0x44, then load 0x44: the load hits with no stall and returns 0xDEADBEEF.
- WAYS = 2, SETS = 16 conflict sequence:
  - load 0x000, then 0x200 (same set, both fill);
  - store to 0x000, then load 0x400;
  - the PLRU victim is the 0x200 way and it is clean, so there is no write-back.
- Same sequence, but with the store going to 0x200 before loading 0x400:
  - a WRITEBACK to 0x200 with the updated line precedes the ALLOCATE of 0x400;
  - total stall is 23 cycles.
- Assert `rst_i` during ALLOCATE:
  - `mem_enable_o` = 0 on the next cycle;
  - a subsequent ack is ignored;
  - the next load of the same address misses again.
- WAYS = 1: every conflicting address evicts, and behaviour matches the direct-mapped `dcache_top` cycle for cycle.
